// File: rtl/fifo_sync_param_pkg.sv
// Shared helpers for the parametrised synchronous FIFO family.
// Holds only the constant functions used to size address ports.
package fifo_sync_param_pkg;

  // Ceiling log2 for elaboration-time sizing; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = (value > 1) ? value - 1 : 0;
    r = 0;
    while (v != 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Pointer, occupancy and flag logic for a power-of-two synchronous FIFO.
// Independent of the storage type so it can sit beside distributed or block RAM.
module fifo_sync_ptr #(
  parameter int unsigned N_log      = 3,
  parameter int unsigned AFULL_THR  = 6,
  parameter int unsigned AEMPTY_THR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  output logic             o_wr_fire_c,
  output logic             o_rd_fire_c,
  output logic [N_log-1:0] o_wr_ptr,
  output logic [N_log-1:0] o_rd_ptr,
  output logic [N_log-1:0] o_rd_ptr_nxt_c,
  output logic             o_nonempty_nxt_c,
  output logic             o_full,
  output logic             o_almost_full,
  output logic             o_empty,
  output logic             o_almost_empty,
  output logic             o_wr_err,
  output logic             o_rd_err,
  output logic [N_log:0]   o_words
);

  localparam int unsigned PW    = N_log;
  localparam int unsigned CW    = N_log + 1;
  localparam int unsigned DEPTH = 1 << N_log;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] words_q, words_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          empty_q, empty_d;
  logic          aempty_q, aempty_d;
  logic          wr_err_q, wr_err_d;
  logic          rd_err_q, rd_err_d;
  logic          wr_fire_c;
  logic          rd_fire_c;

  // Accept decisions use only the registered flags; flush discards both requests.
  always_comb begin
    wr_fire_c = i_wr_en && !full_q  && !i_flush;
    rd_fire_c = i_rd_en && !empty_q && !i_flush;
    wr_err_d  = i_wr_en && full_q   && !i_flush;
    rd_err_d  = i_rd_en && empty_q  && !i_flush;

    wr_ptr_d  = wr_ptr_q + PW'(wr_fire_c);
    rd_ptr_d  = rd_ptr_q + PW'(rd_fire_c);
    words_d   = words_q + CW'(wr_fire_c) - CW'(rd_fire_c);

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      words_d  = '0;
    end

    full_d   = (words_d == CW'(DEPTH));
    empty_d  = (words_d == '0);
    afull_d  = (words_d >= CW'(AFULL_THR));
    aempty_d = (words_d <= CW'(AEMPTY_THR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      words_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      words_q  <= words_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  assign o_wr_fire_c      = wr_fire_c;
  assign o_rd_fire_c      = rd_fire_c;
  assign o_wr_ptr         = wr_ptr_q;
  assign o_rd_ptr         = rd_ptr_q;
  assign o_rd_ptr_nxt_c   = rd_ptr_d;
  assign o_nonempty_nxt_c = !empty_d;
  assign o_full           = full_q;
  assign o_almost_full    = afull_q;
  assign o_empty          = empty_q;
  assign o_almost_empty   = aempty_q;
  assign o_wr_err         = wr_err_q;
  assign o_rd_err         = rd_err_q;
  assign o_words          = words_q;

endmodule

// File: rtl/xil_dmem_tp.sv
// Two-port distributed memory: synchronous write, asynchronous read.
// No reset on the array; readers must only consume words that were written.
module xil_dmem_tp
  import fifo_sync_param_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [clog2(DEPTH)-1:0]  i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [clog2(DEPTH)-1:0]  i_raddr,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: distributed storage, registered read data,
// optional first-word-fall-through presentation of the head word.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned N_log      = 3,
  parameter int unsigned FWFT       = 0,
  parameter int unsigned AFULL_THR  = 6,
  parameter int unsigned AEMPTY_THR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_en,
  output logic              o_full,
  output logic              o_almost_full,
  output logic              o_wr_err,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty,
  output logic              o_almost_empty,
  output logic              o_rd_err,
  output logic [N_log:0]    o_words
);

  localparam int unsigned DEPTH = 1 << N_log;

  logic              wr_fire_c;
  logic              rd_fire_c;
  logic [N_log-1:0]  wr_ptr;
  logic [N_log-1:0]  rd_ptr;
  logic [N_log-1:0]  rd_ptr_nxt_c;
  logic              nonempty_nxt_c;
  logic [N_log-1:0]  rd_addr_c;
  logic [DATA_W-1:0] mem_rdata_c;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  fifo_sync_ptr #(
    .N_log      (N_log),
    .AFULL_THR  (AFULL_THR),
    .AEMPTY_THR (AEMPTY_THR)
  ) u_ptr (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_flush          (i_flush),
    .i_wr_en          (i_wr_en),
    .i_rd_en          (i_rd_en),
    .o_wr_fire_c      (wr_fire_c),
    .o_rd_fire_c      (rd_fire_c),
    .o_wr_ptr         (wr_ptr),
    .o_rd_ptr         (rd_ptr),
    .o_rd_ptr_nxt_c   (rd_ptr_nxt_c),
    .o_nonempty_nxt_c (nonempty_nxt_c),
    .o_full           (o_full),
    .o_almost_full    (o_almost_full),
    .o_empty          (o_empty),
    .o_almost_empty   (o_almost_empty),
    .o_wr_err         (o_wr_err),
    .o_rd_err         (o_rd_err),
    .o_words          (o_words)
  );

  xil_dmem_tp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (wr_fire_c),
    .i_waddr (wr_ptr),
    .i_wdata (i_wr_data),
    .i_raddr (rd_addr_c),
    .o_rdata (mem_rdata_c)
  );

  // FWFT looks ahead to the post-edge head; standard mode reads the current head.
  assign rd_addr_c = (FWFT != 0) ? rd_ptr_nxt_c : rd_ptr;

  // A write landing on the next head slot is not in the array yet, so bypass it.
  always_comb begin
    rd_data_d = rd_data_q;
    if (FWFT != 0) begin
      if (nonempty_nxt_c) begin
        rd_data_d = (wr_fire_c && (wr_ptr == rd_ptr_nxt_c)) ? i_wr_data : mem_rdata_c;
      end
    end else if (rd_fire_c) begin
      rd_data_d = mem_rdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_rd_data = rd_data_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-mode and an FWFT instance share stimulus
// and are compared against a queue-based model of the FIFO.
module tb_fifo_sync_param;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_LOG  = 3;
  localparam int unsigned D      = 8;
  localparam int unsigned AFT    = 6;
  localparam int unsigned AET    = 1;

  logic              clk;
  logic              rst_n;
  logic              i_flush;
  logic [DATA_W-1:0] i_wr_data;
  logic              i_wr_en;
  logic              i_rd_en;

  logic              s_full, s_afull, s_wr_err, s_empty, s_aempty, s_rd_err;
  logic [DATA_W-1:0] s_rd_data;
  logic [N_LOG:0]    s_words;
  logic              f_full, f_afull, f_wr_err, f_empty, f_aempty, f_rd_err;
  logic [DATA_W-1:0] f_rd_data;
  logic [N_LOG:0]    f_words;

  int n_checks;
  int n_errors;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_std;
  logic [DATA_W-1:0] m_fwft;
  logic              m_wr_err;
  logic              m_rd_err;

  fifo_sync_param #(
    .DATA_W(DATA_W), .N_log(N_LOG), .FWFT(0), .AFULL_THR(AFT), .AEMPTY_THR(AET)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_wr_data(i_wr_data),
    .i_wr_en(i_wr_en), .o_full(s_full), .o_almost_full(s_afull),
    .o_wr_err(s_wr_err), .i_rd_en(i_rd_en), .o_rd_data(s_rd_data),
    .o_empty(s_empty), .o_almost_empty(s_aempty), .o_rd_err(s_rd_err),
    .o_words(s_words)
  );

  fifo_sync_param #(
    .DATA_W(DATA_W), .N_log(N_LOG), .FWFT(1), .AFULL_THR(AFT), .AEMPTY_THR(AET)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_wr_data(i_wr_data),
    .i_wr_en(i_wr_en), .o_full(f_full), .o_almost_full(f_afull),
    .o_wr_err(f_wr_err), .i_rd_en(i_rd_en), .o_rd_data(f_rd_data),
    .o_empty(f_empty), .o_almost_empty(f_aempty), .o_rd_err(f_rd_err),
    .o_words(f_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("s_words",   32'(s_words),  32'(sz));
    chk("f_words",   32'(f_words),  32'(sz));
    chk("s_full",    32'(s_full),   32'(sz == D));
    chk("f_full",    32'(f_full),   32'(sz == D));
    chk("s_empty",   32'(s_empty),  32'(sz == 0));
    chk("f_empty",   32'(f_empty),  32'(sz == 0));
    chk("s_afull",   32'(s_afull),  32'(sz >= AFT));
    chk("f_afull",   32'(f_afull),  32'(sz >= AFT));
    chk("s_aempty",  32'(s_aempty), 32'(sz <= AET));
    chk("f_aempty",  32'(f_aempty), 32'(sz <= AET));
    chk("s_wr_err",  32'(s_wr_err), 32'(m_wr_err));
    chk("f_wr_err",  32'(f_wr_err), 32'(m_wr_err));
    chk("s_rd_err",  32'(s_rd_err), 32'(m_rd_err));
    chk("f_rd_err",  32'(f_rd_err), 32'(m_rd_err));
    chk("s_rd_data", 32'(s_rd_data), 32'(m_std));
    chk("f_rd_data", 32'(f_rd_data), 32'(m_fwft));
  endtask

  // Drive one cycle of requests, advance the model across the edge, then check.
  task automatic cycle(input logic we, input logic [DATA_W-1:0] wd,
                       input logic re, input logic fl);
    bit wacc;
    bit racc;
    i_wr_en   = we;
    i_wr_data = wd;
    i_rd_en   = re;
    i_flush   = fl;
    wacc     = we && !fl && (q.size() < D);
    racc     = re && !fl && (q.size() > 0);
    m_wr_err = we && !fl && (q.size() == D);
    m_rd_err = re && !fl && (q.size() == 0);
    if (fl) begin
      q.delete();
    end else begin
      if (racc) m_std = q.pop_front();
      if (wacc) q.push_back(wd);
    end
    if (q.size() > 0) m_fwft = q[0];
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    m_std    = '0;
    m_fwft   = '0;
    m_wr_err = 1'b0;
    m_rd_err = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    i_flush   = 1'b0;
    i_wr_en   = 1'b0;
    i_rd_en   = 1'b0;
    i_wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Fill to full, then one rejected write and an idle cycle to end the pulse.
    for (int i = 0; i < 8; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Drain, then one rejected read; standard-mode data must hold 0x1007.
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("hold_1007", 32'(s_rd_data), 32'h1007);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0);

    // Single word into an empty FIFO: FWFT shows it before any read.
    cycle(1'b1, 16'hBEEF, 1'b0, 1'b0);
    chk("fwft_beef", 32'(f_rd_data), 32'hBEEF);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    // Streaming at occupancy 4 across pointer wrap.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 16'(i + 4), 1'b1, 1'b0);
      chk("stream_data", 32'(s_rd_data), 32'(i));
    end

    // Top up to full, then read and write together: write is rejected.
    for (int i = 0; i < 4; i++) cycle(1'b1, 16'(16'h2000 + 16'(i)), 1'b0, 1'b0);
    cycle(1'b1, 16'h3333, 1'b1, 1'b0);
    chk("full_rw_words", 32'(s_words), 32'd7);

    // Bring occupancy to 5, then flush alongside a write and a read.
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);
    cycle(1'b1, 16'h4444, 1'b1, 1'b1);
    chk("flush_words", 32'(s_words), 32'd0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 16'($urandom),
            1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h5000 + 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h5100 + 16'(i), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 16'hA5A5, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
